// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with registered outputs and flush/stall control.
// Define PIPE_SKID_EN for a 2-entry skid buffer; the default build holds a single entry.
module pipe_stage_reg #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy
);

  logic              r_mainValid;
  logic [INST_W-1:0] r_mainInst;
  logic [PC_W-1:0]   r_mainPc;
  logic              w_accept;
  logic              w_pop;

  assign w_accept  = in_valid && in_ready && !flush;
  assign w_pop     = r_mainValid && out_ready && !stall && !flush;
  assign out_valid = r_mainValid;
  assign out_inst  = r_mainInst;
  assign out_pc    = r_mainPc;

`ifdef PIPE_SKID_EN
  logic              r_skidValid;
  logic [INST_W-1:0] r_skidInst;
  logic [PC_W-1:0]   r_skidPc;

  // The skid entry is only ever occupied when the stage is full, so its
  // valid bit alone gives a registered ready independent of out_ready/stall.
  assign in_ready  = !r_skidValid;
  assign occupancy = {r_skidValid, r_mainValid & ~r_skidValid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mainValid <= 1'b0;
      r_mainInst  <= BUBBLE_INST;
      r_mainPc    <= '0;
      r_skidValid <= 1'b0;
      r_skidInst  <= BUBBLE_INST;
      r_skidPc    <= '0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_mainInst  <= BUBBLE_INST;
      r_skidValid <= 1'b0;
    end else if (r_skidValid) begin
      if (w_pop) begin
        r_mainInst  <= r_skidInst;
        r_mainPc    <= r_skidPc;
        r_skidValid <= 1'b0;
      end
    end else if (r_mainValid) begin
      if (w_accept && w_pop) begin
        r_mainInst <= in_inst;
        r_mainPc   <= in_pc;
      end else if (w_accept) begin
        r_skidInst  <= in_inst;
        r_skidPc    <= in_pc;
        r_skidValid <= 1'b1;
      end else if (w_pop) begin
        r_mainValid <= 1'b0;
        r_mainInst  <= BUBBLE_INST;
      end
    end else if (w_accept) begin
      r_mainValid <= 1'b1;
      r_mainInst  <= in_inst;
      r_mainPc    <= in_pc;
    end
  end
`else
  // Single entry can only take a new input when it is empty or draining now.
  assign in_ready  = !r_mainValid || (out_ready && !stall);
  assign occupancy = {1'b0, r_mainValid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mainValid <= 1'b0;
      r_mainInst  <= BUBBLE_INST;
      r_mainPc    <= '0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_mainInst  <= BUBBLE_INST;
    end else if (w_accept) begin
      r_mainValid <= 1'b1;
      r_mainInst  <= in_inst;
      r_mainPc    <= in_pc;
    end else if (w_pop) begin
      r_mainValid <= 1'b0;
      r_mainInst  <= BUBBLE_INST;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// compared against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  occupancy;

  pipe_stage_reg #(.INST_W(32), .PC_W(32), .BUBBLE_INST(BUBBLE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t      q[$];
  logic [31:0] expPc;
  int          checks;
  int          errors;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic applyStimulus(input logic iRst, input logic iValid, input logic iStall,
                               input logic iFlush, input logic iOutReady, input logic [31:0] iPc);
    logic   expReady;
    logic   doAccept;
    logic   doPop;
    entry_t e;
    @(negedge clk);
    rst       = iRst;
    in_valid  = iValid;
    in_inst   = $urandom;
    in_pc     = iPc;
    stall     = iStall;
    flush     = iFlush;
    out_ready = iOutReady;
    #1;
    if (CAP == 2) expReady = (q.size() < 2);
    else          expReady = (q.size() == 0) || (iOutReady && !iStall);
    checkOutput("in_ready",  32'(in_ready),  32'(expReady));
    checkOutput("out_valid", 32'(out_valid), 32'(q.size() > 0));
    checkOutput("out_inst",  out_inst,       (q.size() > 0) ? q[0].inst : BUBBLE);
    checkOutput("out_pc",    out_pc,         expPc);
    checkOutput("occupancy", 32'(occupancy), 32'(q.size()));

    doAccept = iValid && expReady && !iFlush;
    doPop    = (q.size() > 0) && iOutReady && !iStall && !iFlush;
    if (iRst) begin
      q.delete();
      expPc = '0;
    end else if (iFlush) begin
      q.delete();
    end else begin
      if (doPop) void'(q.pop_front());
      if (doAccept) begin
        e.inst = in_inst;
        e.pc   = in_pc;
        q.push_back(e);
      end
      if (q.size() > 0) expPc = q[0].pc;
    end
  endtask

  initial begin
    logic [31:0] nextPc;
    clk = 0; rst = 1; in_valid = 0; in_inst = 0; in_pc = 0;
    stall = 0; flush = 0; out_ready = 0;
    checks = 0; errors = 0;
    q.delete();
    expPc = '0;
    repeat (2) @(posedge clk);

    // Streaming with one-cycle latency
    applyStimulus(0, 1, 0, 0, 1, 32'h0);
    applyStimulus(0, 1, 0, 0, 1, 32'h4);
    applyStimulus(0, 1, 0, 0, 1, 32'h8);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);

    // Backpressure then release
    applyStimulus(0, 1, 0, 0, 0, 32'h100);
    applyStimulus(0, 1, 0, 0, 0, 32'h104);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);

    // Stall holds the output entry
    applyStimulus(0, 1, 0, 0, 0, 32'h200);
    repeat (3) applyStimulus(0, 0, 1, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);

    // Flush together with stall while holding entries
    applyStimulus(0, 1, 0, 0, 0, 32'h300);
    applyStimulus(0, 1, 0, 0, 0, 32'h304);
    applyStimulus(0, 1, 1, 1, 0, 32'h308);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);

    // Reset mid-operation
    applyStimulus(0, 1, 0, 0, 0, 32'h400);
    applyStimulus(0, 1, 0, 0, 0, 32'h404);
    applyStimulus(1, 1, 0, 0, 1, 32'h408);
    applyStimulus(0, 0, 0, 0, 1, 32'h0);

    // Random traffic with unique PCs so loss or duplication shows up
    nextPc = 32'h1000;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) != 0),
                    nextPc);
      nextPc = nextPc + 32'd4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
